// File: rtl/cpu_peripheral_bus.sv
// CPU-to-peripheral bus bridge: decodes held CPU requests to one-hot slots and keeps pending IRQs.
// Optional forced-completion timeout is enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_peripheral_bus #(
    parameter int PERIPH_COUNT   = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_2x,
    input  logic                      reset,
    input  logic                      cpu_mem_valid_2x,
    input  logic [23:0]               cpu_address_2x,
    input  logic [3:0]                cpu_wstrb_2x,
    input  logic [31:0]               cpu_write_data_2x,
    input  logic [31:0]               cpu_eoi_2x,
    output logic                      cpu_mem_ready,
    output logic [31:0]               cpu_read_data,
    output logic [31:0]               cpu_irq,
    output logic [PERIPH_COUNT-1:0]   periph_sel,
    output logic [23:0]               periph_address,
    output logic [31:0]               periph_write_data,
    output logic [3:0]                periph_wstrb,
    output logic                      periph_write_en,
    output logic                      periph_read_en,
    input  logic [PERIPH_COUNT-1:0]   periph_ready,
    input  logic [32*PERIPH_COUNT-1:0] periph_read_data,
    input  logic [31:0]               periph_irq,
    output logic                      bus_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0]              slot;
    logic                    mapped;
    logic [PERIPH_COUNT-1:0] sel_dec;
    logic                    ack;
    logic [31:0]             rd_mux;

    logic [PERIPH_COUNT-1:0] sel_nx;
    logic [23:0]             addr_nx;
    logic [31:0]             wdata_nx;
    logic [3:0]              wstrb_nx;
    logic                    wen_nx;
    logic                    ren_nx;
    logic                    rdy_nx;
    logic [31:0]             rdata_nx;
    logic [31:0]             irq_nx;

    assign slot    = cpu_address_2x[23:20];
    assign mapped  = ({28'd0, slot} < PERIPH_COUNT);
    assign sel_dec = PERIPH_COUNT'(1) << slot;
    assign ack     = |(periph_ready & periph_sel);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < PERIPH_COUNT; i++) begin
            if (periph_sel[i]) rd_mux = rd_mux | periph_read_data[32*i +: 32];
        end
    end

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic             tmo_flag, tmo_flag_nx;
    logic             tmo_hit;

    assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign bus_timeout = tmo_flag;

    always_ff @(posedge clk_2x) begin
        if (reset) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt  <= tmo_cnt_nx;
            tmo_flag <= tmo_flag_nx;
        end
    end
`else
    assign bus_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        sel_nx   = periph_sel;
        addr_nx  = periph_address;
        wdata_nx = periph_write_data;
        wstrb_nx = periph_wstrb;
        wen_nx   = 1'b0;
        ren_nx   = 1'b0;
        rdy_nx   = cpu_mem_ready;
        rdata_nx = cpu_read_data;
`ifdef CPU_BUS_TIMEOUT_EN
        tmo_cnt_nx  = tmo_cnt;
        tmo_flag_nx = tmo_flag;
`endif
        // Set beats clear so an IRQ arriving with its own EOI is not lost.
        irq_nx = (cpu_irq & ~cpu_eoi_2x) | periph_irq;

        unique case (state)
            IDLE: begin
                if (cpu_mem_valid_2x) begin
                    addr_nx  = cpu_address_2x;
                    wdata_nx = cpu_write_data_2x;
                    wstrb_nx = cpu_wstrb_2x;
                    if (mapped) begin
                        sel_nx   = sel_dec;
                        wen_nx   = |cpu_wstrb_2x;
                        ren_nx   = ~|cpu_wstrb_2x;
                        state_nx = STROBE;
`ifdef CPU_BUS_TIMEOUT_EN
                        tmo_cnt_nx = '0;
`endif
                    end else begin
                        rdata_nx = '0;
                        rdy_nx   = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            STROBE, WAIT: begin
                if (ack) begin
                    rdata_nx = (|periph_wstrb) ? 32'd0 : rd_mux;
                    rdy_nx   = 1'b1;
                    sel_nx   = '0;
                    state_nx = DONE;
`ifdef CPU_BUS_TIMEOUT_EN
                end else if (tmo_hit) begin
                    rdata_nx    = 32'hFFFF_FFFF;
                    tmo_flag_nx = 1'b1;
                    rdy_nx      = 1'b1;
                    sel_nx      = '0;
                    state_nx    = DONE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                    state_nx   = WAIT;
                end
`else
                end else begin
                    state_nx = WAIT;
                end
`endif
            end
            DONE: begin
                // Never start a new access here: one request, one strobe.
                if (!cpu_mem_valid_2x) begin
                    rdy_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_2x) begin
        if (reset) begin
            state             <= IDLE;
            periph_sel        <= '0;
            periph_address    <= '0;
            periph_write_data <= '0;
            periph_wstrb      <= '0;
            periph_write_en   <= 1'b0;
            periph_read_en    <= 1'b0;
            cpu_mem_ready     <= 1'b0;
            cpu_read_data     <= '0;
            cpu_irq           <= '0;
        end else begin
            state             <= state_nx;
            periph_sel        <= sel_nx;
            periph_address    <= addr_nx;
            periph_write_data <= wdata_nx;
            periph_wstrb      <= wstrb_nx;
            periph_write_en   <= wen_nx;
            periph_read_en    <= ren_nx;
            cpu_mem_ready     <= rdy_nx;
            cpu_read_data     <= rdata_nx;
            cpu_irq           <= irq_nx;
        end
    end

endmodule
